// File: rtl/text_mem_pkg.sv
// rtl/text_mem_pkg.sv - shared types for the text BRAM arbiter
package text_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

endpackage

// File: rtl/text_mem_starve_cnt.sv
// rtl/text_mem_starve_cnt.sv - saturating count of consecutive denied load-store cycles
module text_mem_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/text_mem_arbiter.sv
// rtl/text_mem_arbiter.sv - shares the single-port text BRAM between fetch, load-store reads and the loader
module text_mem_arbiter
  import text_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4,
  parameter int BOOT_LOAD    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [XLEN-1:0]       if_data,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  output logic                  ls_gnt,
  output logic                  ls_valid,
  output logic [XLEN-1:0]       ls_data,
  input  logic                  ld_en,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [XLEN-1:0]       ld_wdata,
  output logic                  ld_ack,
  output logic [ADDR_WIDTH:0]   ld_words,
  output logic                  core_hold,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam state_t RESET_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;
  localparam logic [ADDR_WIDTH:0] WORDS_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t state, next_state;
  owner_t owner;
  logic   starve_full;
  logic   ld_wr;

  text_mem_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .req     (ls_req),
    .gnt     (ls_gnt),
    .at_limit(starve_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_STATE;
      owner     <= OWN_NONE;
      ld_ack    <= 1'b0;
      ld_words  <= '0;
      core_hold <= (BOOT_LOAD != 0);
    end else begin
      state     <= next_state;
      ld_ack    <= ld_wr;
      core_hold <= (next_state != ST_RUN);
      if (ls_gnt) begin
        owner <= OWN_LS;
      end else if (if_gnt) begin
        owner <= OWN_IF;
      end else begin
        owner <= OWN_NONE;
      end
      if (state != ST_LOAD && next_state == ST_LOAD) begin
        ld_words <= '0;
      end else if (ld_wr && ld_words != WORDS_FULL) begin
        ld_words <= ld_words + 1'b1;
      end
    end
  end

  // A read granted last cycle is still owed its VALID, so loader entry waits one cycle for it.
  always_comb begin
    next_state = state;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    ld_wr      = 1'b0;
    case (state)
      ST_RUN: begin
        if (ld_en) begin
          next_state = (owner != OWN_NONE) ? ST_DRAIN : ST_LOAD;
        end else begin
          ls_gnt = ls_req && (!if_req || starve_full);
          if_gnt = if_req && !ls_gnt;
        end
      end
      ST_DRAIN: begin
        next_state = ST_LOAD;
      end
      ST_LOAD: begin
        ld_wr = ld_we;
        if (!ld_en) begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_RUN;
      end
    endcase
  end

  assign mem_en    = if_gnt || ls_gnt || ld_wr;
  assign mem_we    = ld_wr;
  assign mem_addr  = ld_wr ? ld_addr : (ls_gnt ? ls_addr : if_addr);
  assign mem_wdata = ld_wdata;

  // A read in flight when reset arrives is dropped rather than delivered.
  assign if_valid = (owner == OWN_IF) && !rst;
  assign ls_valid = (owner == OWN_LS) && !rst;
  assign if_data  = if_valid ? mem_rdata : '0;
  assign ls_data  = ls_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// tb/tb_text_mem_arbiter.sv - bench for text_mem_arbiter with a word-level memory model
module tb_text_mem_arbiter;

  localparam int AW  = 12;
  localparam int LIM = 4;
  localparam int BW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, if_req, ls_req, ld_en, ld_we;
  logic [AW-1:0] if_addr, ls_addr, ld_addr, mem_addr;
  logic [31:0]   ld_wdata, mem_rdata, if_data, ls_data, mem_wdata;
  logic          if_gnt, if_valid, ls_gnt, ls_valid, ld_ack, core_hold, mem_en, mem_we;
  logic [AW:0]   ld_words;

  logic          if_req_b, ls_req_b, ld_en_b, ld_we_b;
  logic [BW-1:0] if_addr_b, ls_addr_b, ld_addr_b, mem_addr_b;
  logic [31:0]   ld_wdata_b, mem_rdata_b, if_data_b, ls_data_b, mem_wdata_b;
  logic          if_gnt_b, if_valid_b, ls_gnt_b, ls_valid_b, ld_ack_b, core_hold_b, mem_en_b, mem_we_b;
  logic [BW:0]   ld_words_b;

  text_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM), .BOOT_LOAD(0)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_data(ls_data),
    .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .ld_words(ld_words), .core_hold(core_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  text_mem_arbiter #(.ADDR_WIDTH(BW), .STARVE_LIMIT(1), .BOOT_LOAD(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_valid(if_valid_b), .if_data(if_data_b),
    .ls_req(ls_req_b), .ls_addr(ls_addr_b), .ls_gnt(ls_gnt_b), .ls_valid(ls_valid_b), .ls_data(ls_data_b),
    .ld_en(ld_en_b), .ld_we(ld_we_b), .ld_addr(ld_addr_b), .ld_wdata(ld_wdata_b), .ld_ack(ld_ack_b),
    .ld_words(ld_words_b), .core_hold(core_hold_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  logic        ram_init;
  logic [31:0] ram  [0:(1<<AW)-1];
  logic [31:0] gold [0:(1<<AW)-1];

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= seed_word(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int sc;
  int pend_own;
  int ls_wins;
  logic [AW-1:0] pend_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle: expected winner from the priority rule, expected read data from the golden array.
  task automatic step(input logic ir, input logic [AW-1:0] ia, input logic lr, input logic [AW-1:0] la);
    logic e_ls, e_if;
    if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
    @(negedge clk);
    e_ls = lr && (!ir || sc == LIM);
    e_if = ir && !e_ls;
    chk("if_gnt", if_gnt, e_if);
    chk("ls_gnt", ls_gnt, e_ls);
    chk("mem_en", mem_en, e_ls || e_if);
    if (e_ls || e_if) chk("mem_addr", mem_addr, e_ls ? la : ia);
    chk("if_valid", if_valid, pend_own == 1);
    chk("if_data", if_data, (pend_own == 1) ? gold[pend_addr] : 32'h0);
    chk("ls_valid", ls_valid, pend_own == 2);
    chk("ls_data", ls_data, (pend_own == 2) ? gold[pend_addr] : 32'h0);
    if (ls_gnt) ls_wins++;
    if (!lr || e_ls) sc = 0;
    else if (sc < LIM) sc = sc + 1;
    pend_own  = e_ls ? 2 : (e_if ? 1 : 0);
    pend_addr = e_ls ? la : ia;
    tick();
  endtask

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    if_req = 0; ls_req = 0; ld_en = 0; ld_we = 0;
    if_addr = '0; ls_addr = '0; ld_addr = '0; ld_wdata = '0;
    if_req_b = 0; ls_req_b = 0; ld_en_b = 1; ld_we_b = 0;
    if_addr_b = '0; ls_addr_b = '0; ld_addr_b = '0; ld_wdata_b = '0; mem_rdata_b = '0;
    sc = 0; pend_own = 0; pend_addr = '0; ls_wins = 0;
    for (int i = 0; i < (1<<AW); i++) gold[i] = seed_word(i);
    tick();
    ram_init = 1'b0;
    tick();

    // reset state
    @(negedge clk);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_ls_valid", ls_valid, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_data", ls_data, 0);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_ld_words", ld_words, 0);
    chk("rst_core_hold", core_hold, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_core_hold_boot", core_hold_b, 1);
    chk("rst_ld_words_boot", ld_words_b, 0);
    tick();
    rst = 1'b0;

    // fetch stream 0..3
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);

    // both requesting: IF x4 then LS, repeated
    ls_wins = 0;
    for (int i = 0; i < 10; i++) step(1'b1, AW'($urandom), 1'b1, AW'($urandom));
    chk("ls_wins_10", ls_wins, 2);
    step(1'b0, '0, 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 150; i++)
      step(1'($urandom), AW'($urandom), ($urandom_range(0, 3) != 0), AW'($urandom));
    step(1'b0, '0, 1'b0, '0);

    // loader entry with a fetch outstanding
    step(1'b1, AW'(5), 1'b0, '0);
    ld_en = 1; if_req = 1; if_addr = AW'(6);
    @(negedge clk);
    chk("drain_if_gnt", if_gnt, 0);
    chk("drain_mem_en", mem_en, 0);
    chk("drain_if_valid", if_valid, 1);
    chk("drain_if_data", if_data, gold[5]);
    chk("drain_hold_pre", core_hold, 0);
    tick();
    ld_we = 1; ld_addr = AW'(12'h010); ld_wdata = 32'h00150513;
    @(negedge clk);
    chk("drain_hold", core_hold, 1);
    chk("drain_no_valid", if_valid, 0);
    chk("drain_no_write", mem_we, 0);
    chk("drain_no_en", mem_en, 0);
    tick();
    @(negedge clk);
    chk("load_if_gnt", if_gnt, 0);
    chk("load_mem_we", mem_we, 1);
    chk("load_mem_addr", mem_addr, 12'h010);
    chk("load_mem_wdata", mem_wdata, 32'h00150513);
    chk("load_words0", ld_words, 0);
    chk("load_hold", core_hold, 1);
    gold[12'h010] = 32'h00150513;
    tick();
    ld_addr = AW'(12'h011); ld_wdata = 32'hfff62693; ld_en = 0;
    @(negedge clk);
    chk("load_ack1", ld_ack, 1);
    chk("load_words1", ld_words, 1);
    chk("load_fall_we", mem_we, 1);
    chk("load_fall_addr", mem_addr, 12'h011);
    gold[12'h011] = 32'hfff62693;
    tick();
    ld_we = 0; if_req = 0;
    @(negedge clk);
    chk("load_ack2", ld_ack, 1);
    chk("load_words2", ld_words, 2);
    chk("run_hold", core_hold, 0);
    chk("run_no_we", mem_we, 0);
    tick();
    pend_own = 0; sc = 0;
    step(1'b1, AW'(12'h010), 1'b0, '0);
    step(1'b1, AW'(12'h011), 1'b0, '0);
    step(1'b0, '0, 1'b1, AW'(12'h010));
    step(1'b0, '0, 1'b0, '0);

    // loader write outside LOAD is ignored
    ld_we = 1; ld_addr = AW'(12'h020); ld_wdata = 32'hdeadbeef;
    @(negedge clk);
    chk("stray_we", mem_we, 0);
    chk("stray_en", mem_en, 0);
    tick();
    ld_we = 0;
    @(negedge clk);
    chk("stray_ack", ld_ack, 0);
    tick();
    step(1'b1, AW'(12'h020), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);

    // reset the cycle after a fetch grant
    if_req = 1; if_addr = AW'(7);
    @(negedge clk);
    chk("pre_rst_gnt", if_gnt, 1);
    tick();
    rst = 1; if_req = 0;
    @(negedge clk);
    chk("rst_drop_valid", if_valid, 0);
    chk("rst_drop_data", if_data, 0);
    tick();
    @(negedge clk);
    chk("rst2_ld_words", ld_words, 0);
    chk("rst2_hold", core_hold, 0);
    chk("rst2_hold_boot", core_hold_b, 1);
    chk("rst2_words_boot", ld_words_b, 0);
    tick();
    rst = 0; pend_own = 0; sc = 0;
    step(1'b1, AW'(7), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);

    // boot-load instance: word counter saturates at depth
    ld_we_b = 1;
    for (int i = 0; i < 2; i++) begin
      ld_addr_b = BW'(i); ld_wdata_b = 32'(i);
      tick();
    end
    @(negedge clk);
    chk("boot_words2", ld_words_b, 2);
    chk("boot_ack", ld_ack_b, 1);
    tick();
    for (int i = 0; i < 4; i++) tick();
    ld_we_b = 0;
    @(negedge clk);
    chk("boot_words_sat", ld_words_b, 4);
    chk("boot_hold", core_hold_b, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
